// File: rtl/m_game_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | m_game_sequencer                                                           |
// | Game-phase sequencer: start/done handshakes, frame timer, lives and level. |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module m_game_sequencer #(
  parameter int FRAME_DIV     = 25000000,
  parameter int LIVES         = 3,
  parameter int LIVES_W       = 2,
  parameter int MAX_LEVEL     = 7,
  parameter int LEVEL_W       = 3,
  parameter int RESPAWN_TICKS = 2
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               enable,
  input  logic               start_req,
  input  logic               pause_key,
  output logic               logic_start,
  input  logic               logic_done,
  input  logic               collided,
  input  logic               level_clear,
  output logic               render_start,
  input  logic               render_done,
  output logic               screen_start,
  input  logic               screen_done,
  output logic [1:0]         screen_sel,
  output logic [2:0]         state_o,
  output logic [LIVES_W-1:0] lives,
  output logic [LEVEL_W-1:0] level,
  output logic               level_up,
  output logic               respawn,
  output logic               overrun
);

  localparam int CNT_W = (FRAME_DIV > 2) ? $clog2(FRAME_DIV) : 1;
  localparam int RSP_W = (RESPAWN_TICKS > 0) ? $clog2(RESPAWN_TICKS + 1) : 1;

  localparam logic [CNT_W-1:0]   c_CNT_MAX   = CNT_W'(FRAME_DIV - 1);
  localparam logic [RSP_W-1:0]   c_RSP_TICKS = RSP_W'(RESPAWN_TICKS);
  localparam logic [LIVES_W-1:0] c_LIVES     = LIVES_W'(LIVES);
  localparam logic [LEVEL_W-1:0] c_MAX_LEVEL = LEVEL_W'(MAX_LEVEL);

  typedef enum logic [2:0] {
    S_GREETING  = 3'd0,
    S_LOGIC     = 3'd1,
    S_RENDER    = 3'd2,
    S_WAIT      = 3'd3,
    S_PAUSED    = 3'd4,
    S_LIFE_LOST = 3'd5,
    S_LEVEL_UP  = 3'd6,
    S_GAME_OVER = 3'd7
  } state_t;

  state_t r_state;
  state_t w_next;

  logic               r_fresh;
  logic               r_logic_start, r_render_start, r_screen_start;
  logic               r_level_up, r_respawn, r_overrun, r_pending;
  logic [1:0]         r_screen_sel;
  logic [LIVES_W-1:0] r_lives;
  logic [LEVEL_W-1:0] r_level;
  logic [CNT_W-1:0]   r_cnt;
  logic [RSP_W-1:0]   r_rsp_cnt;
  logic               r_done_seen, r_go_ready, r_pause_q;
  logic               r_ld_pend, r_ld_col, r_ld_clr, r_rd_pend, r_sd_pend;

  logic               w_logic_done, w_collided, w_level_clear;
  logic               w_render_done, w_screen_done;
  logic               w_counting, w_tick, w_pause_edge, w_enter, w_in_frame;
  logic [LIVES_W-1:0] w_lives_dec;
  logic [LEVEL_W-1:0] w_level_inc;

  // Done pulses seen while disabled are replayed once enable returns.
  assign w_logic_done  = enable & (logic_done | r_ld_pend);
  assign w_collided    = logic_done ? collided : r_ld_col;
  assign w_level_clear = logic_done ? level_clear : r_ld_clr;
  assign w_render_done = enable & (render_done | r_rd_pend);
  assign w_screen_done = enable & (screen_done | r_sd_pend);

  assign w_counting   = (r_state != S_PAUSED) && (r_state != S_GREETING);
  assign w_tick       = w_counting && (r_cnt == c_CNT_MAX);
  assign w_pause_edge = pause_key & ~r_pause_q;
  assign w_in_frame   = (r_state == S_LOGIC) || (r_state == S_RENDER);
  assign w_lives_dec  = (r_lives != '0) ? r_lives - LIVES_W'(1) : '0;
  assign w_level_inc  = (r_level >= c_MAX_LEVEL) ? r_level : r_level + LEVEL_W'(1);
  assign w_enter      = (w_next != r_state);

  always_comb begin
    w_next = r_state;
    if (enable) begin
      case (r_state)
        S_GREETING:  if (start_req) w_next = S_LOGIC;
        S_LOGIC: begin
          if (w_logic_done) begin
            if (w_collided)         w_next = (w_lives_dec == '0) ? S_GAME_OVER : S_LIFE_LOST;
            else if (w_level_clear) w_next = S_LEVEL_UP;
            else                    w_next = S_RENDER;
          end
        end
        S_RENDER:    if (w_render_done) w_next = S_WAIT;
        S_WAIT: begin
          if (w_pause_edge)           w_next = S_PAUSED;
          else if (w_tick | r_pending) w_next = S_LOGIC;
        end
        S_PAUSED:    if (w_pause_edge) w_next = S_WAIT;
        S_LIFE_LOST: if (r_done_seen && (r_rsp_cnt == c_RSP_TICKS)) w_next = S_LOGIC;
        S_LEVEL_UP:  if (w_screen_done) w_next = S_LOGIC;
        S_GAME_OVER: if (r_go_ready && start_req) w_next = S_GREETING;
        default:     w_next = S_GREETING;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) r_state <= S_GREETING;
    else       r_state <= w_next;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_ld_pend <= 1'b0;
      r_ld_col  <= 1'b0;
      r_ld_clr  <= 1'b0;
      r_rd_pend <= 1'b0;
      r_sd_pend <= 1'b0;
    end else if (enable) begin
      r_ld_pend <= 1'b0;
      r_rd_pend <= 1'b0;
      r_sd_pend <= 1'b0;
    end else begin
      if (logic_done) begin
        r_ld_pend <= 1'b1;
        r_ld_col  <= collided;
        r_ld_clr  <= level_clear;
      end
      if (render_done) r_rd_pend <= 1'b1;
      if (screen_done) r_sd_pend <= 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_fresh        <= 1'b1;
      r_logic_start  <= 1'b0;
      r_render_start <= 1'b0;
      r_screen_start <= 1'b0;
      r_level_up     <= 1'b0;
      r_respawn      <= 1'b0;
      r_overrun      <= 1'b0;
      r_pending      <= 1'b0;
      r_screen_sel   <= 2'd0;
      r_lives        <= c_LIVES;
      r_level        <= '0;
      r_cnt          <= '0;
      r_rsp_cnt      <= '0;
      r_done_seen    <= 1'b0;
      r_go_ready     <= 1'b0;
      r_pause_q      <= 1'b0;
    end else begin
      r_pause_q <= pause_key;
      if (enable) begin
        // r_fresh marks the first cycle in a state; the start pulse follows it.
        r_fresh        <= w_enter;
        r_logic_start  <= r_fresh && (r_state == S_LOGIC);
        r_render_start <= r_fresh && (r_state == S_RENDER);
        r_screen_start <= r_fresh && ((r_state == S_GREETING) || (r_state == S_LIFE_LOST) ||
                                      (r_state == S_LEVEL_UP) || (r_state == S_GAME_OVER));
        r_level_up     <= w_enter && (w_next == S_LEVEL_UP);
        r_respawn      <= w_enter && (r_state == S_LIFE_LOST);

        if (r_state == S_GREETING && w_enter) r_cnt <= '0;
        else if (w_counting)                  r_cnt <= w_tick ? '0 : r_cnt + CNT_W'(1);

        if (r_state == S_WAIT && w_next == S_LOGIC) r_pending <= 1'b0;
        else if (w_tick && w_in_frame)              r_pending <= 1'b1;
        if (w_tick && w_in_frame) r_overrun <= 1'b1;

        if (r_state == S_GREETING && w_enter) begin
          r_lives <= c_LIVES;
          r_level <= '0;
        end else begin
          if (r_state == S_LOGIC && w_logic_done && w_collided) r_lives <= w_lives_dec;
          if (w_enter && w_next == S_LEVEL_UP)                 r_level <= w_level_inc;
        end

        if (w_enter) begin
          case (w_next)
            S_GREETING:  r_screen_sel <= 2'd0;
            S_GAME_OVER: r_screen_sel <= 2'd1;
            S_LEVEL_UP:  r_screen_sel <= 2'd2;
            S_LIFE_LOST: r_screen_sel <= 2'd3;
            default:     r_screen_sel <= r_screen_sel;
          endcase
          r_done_seen <= 1'b0;
          r_rsp_cnt   <= '0;
          r_go_ready  <= 1'b0;
        end else begin
          if ((r_state == S_LIFE_LOST || r_state == S_GAME_OVER) && w_screen_done)
            r_done_seen <= 1'b1;
          if (r_state == S_LIFE_LOST && r_done_seen && w_tick && r_rsp_cnt != c_RSP_TICKS)
            r_rsp_cnt <= r_rsp_cnt + RSP_W'(1);
          // start_req must be seen low after the game-over screen before it counts.
          if (r_state == S_GAME_OVER && (r_done_seen || w_screen_done) && !start_req)
            r_go_ready <= 1'b1;
        end
      end else begin
        r_logic_start  <= 1'b0;
        r_render_start <= 1'b0;
        r_screen_start <= 1'b0;
        r_level_up     <= 1'b0;
        r_respawn      <= 1'b0;
      end
    end
  end

  assign logic_start  = r_logic_start;
  assign render_start = r_render_start;
  assign screen_start = r_screen_start;
  assign screen_sel   = r_screen_sel;
  assign state_o      = r_state;
  assign lives        = r_lives;
  assign level        = r_level;
  assign level_up     = r_level_up;
  assign respawn      = r_respawn;
  assign overrun      = r_overrun;

endmodule
`default_nettype wire
